// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART PISO transmitter between NREQ byte requesters.
// Latency: req sampled at edge n -> req_ack/piso_data at n, piso_send at n+1, req_done one cycle after PISO idles.
// Backpressure: requesters hold req until req_ack; no grant while a frame or inter-frame gap is in progress or enable is low.
//
// Ports:
//   baud_clk, reset        : baud clock shared with the PISO; asynchronous active-high reset
//   enable                 : allows new grants (a frame in flight always completes)
//   parity_type            : 0 = even, 1 = odd parity over the data byte, sampled at grant
//   req / req_data         : per-requester request level and byte (requester i at [8i+7:8i])
//   req_ack / req_done     : one-cycle pulses when requester i's byte is latched / its frame finished
//   piso_send/_data/_parity: start strobe, byte and parity bit presented to the PISO
//   piso_active, piso_done : PISO status inputs
//   busy, owner            : not idle; index of current or last granted requester
//   timeout_err            : one-cycle pulse when the PISO never started after piso_send
module uart_tx_arbiter #(
    parameter int  NREQ          = 2,
    parameter int  GAP_CYCLES    = 1,
    parameter int  START_TIMEOUT = 4,
    localparam int IW            = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic              baud_clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              parity_type,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ack,
    output logic [NREQ-1:0]   req_done,
    output logic              piso_send,
    output logic [7:0]        piso_data,
    output logic              piso_parity,
    input  logic              piso_active,
    input  logic              piso_done,
    output logic              busy,
    output logic [IW-1:0]     owner,
    output logic              timeout_err
);

    // One extra bit so last + offset can exceed NREQ before the wrap.
    localparam int RW = IW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_ACT,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] last;
    logic [3:0]    to_cnt;
    logic [3:0]    gap_cnt;
    logic          to_hit;
    logic          gap_hit;
    logic          grant_vld;
    logic [IW-1:0] grant_idx;
    logic [RW-1:0] rr_pos;
    logic [7:0]    grant_dat;

    // Counters are compared one ahead so the transition and its pulse land on the same edge.
    assign to_hit  = ({1'b0, to_cnt} + 5'd1) >= 5'(START_TIMEOUT);
    assign gap_hit = ({1'b0, gap_cnt} + 5'd1) >= 5'(GAP_CYCLES);

    // Round-robin search starting just after the last winner, wrapping modulo NREQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_pos    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            rr_pos = {1'b0, last} + RW'(i);
            if (rr_pos >= RW'(NREQ)) begin
                rr_pos = rr_pos - RW'(NREQ);
            end
            if (!grant_vld && req[rr_pos[IW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = rr_pos[IW-1:0];
            end
        end
    end

    always_comb begin
        grant_dat = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IW'(i)) begin
                grant_dat = req_data[8*i +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (enable && grant_vld) state_nxt = S_LOAD;
            S_LOAD:      state_nxt = S_START;
            S_START:     state_nxt = S_WAIT_ACT;
            S_WAIT_ACT: begin
                // A late start on the timeout edge still counts as a start.
                if (piso_active) begin
                    state_nxt = S_WAIT_DONE;
                end else if (to_hit) begin
                    state_nxt = S_GAP;
                end
            end
            S_WAIT_DONE: if (!piso_active && piso_done) state_nxt = S_GAP;
            S_GAP:       if (gap_hit) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs and counters.
    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            req_ack     <= '0;
            req_done    <= '0;
            piso_send   <= 1'b0;
            piso_data   <= 8'h00;
            piso_parity <= 1'b0;
            busy        <= 1'b0;
            owner       <= '0;
            timeout_err <= 1'b0;
            last        <= IW'(NREQ - 1);
            to_cnt      <= '0;
            gap_cnt     <= '0;
        end else begin
            req_ack     <= '0;
            req_done    <= '0;
            piso_send   <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= (state_nxt != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (state_nxt == S_LOAD) begin
                        piso_data   <= grant_dat;
                        piso_parity <= (^grant_dat) ^ parity_type;
                        owner       <= grant_idx;
                        last        <= grant_idx;
                        req_ack     <= NREQ'(1) << grant_idx;
                    end
                end
                S_LOAD:  piso_send <= 1'b1;
                S_START: to_cnt <= '0;
                S_WAIT_ACT: begin
                    if (!piso_active) begin
                        to_cnt <= to_cnt + 4'd1;
                        if (to_hit) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (state_nxt == S_GAP) begin
                        req_done <= NREQ'(1) << owner;
                    end
                end
                S_GAP:   gap_cnt <= gap_cnt + 4'd1;
                default: ;
            endcase
            if (state_nxt == S_GAP && state != S_GAP) begin
                gap_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NREQ = 3;
    localparam int GAP  = 2;
    localparam int TO   = 4;
    localparam int IW   = 2;

    localparam int M_IDLE  = 0;
    localparam int M_SEND  = 1;
    localparam int M_FRAME = 2;
    localparam int M_QUIET = 3;

    logic              baud_clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              parity_type;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ack;
    logic [NREQ-1:0]   req_done;
    logic              piso_send;
    logic [7:0]        piso_data;
    logic              piso_parity;
    logic              piso_active = 1'b0;
    logic              piso_done   = 1'b1;
    logic              busy;
    logic [IW-1:0]     owner;
    logic              timeout_err;

    int checks   = 0;
    int failures = 0;

    always #5 baud_clk = ~baud_clk;

    uart_tx_arbiter #(
        .NREQ(NREQ),
        .GAP_CYCLES(GAP),
        .START_TIMEOUT(TO)
    ) dut (
        .baud_clk(baud_clk),
        .reset(reset),
        .enable(enable),
        .parity_type(parity_type),
        .req(req),
        .req_data(req_data),
        .req_ack(req_ack),
        .req_done(req_done),
        .piso_send(piso_send),
        .piso_data(piso_data),
        .piso_parity(piso_parity),
        .piso_active(piso_active),
        .piso_done(piso_done),
        .busy(busy),
        .owner(owner),
        .timeout_err(timeout_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // PISO model: starts piso_delay negedges after seeing send, stays active piso_len cycles.
    logic piso_en    = 1'b1;
    int   piso_delay = 2;
    int   piso_len   = 6;
    logic piso_lag   = 1'b0;
    int   p_start    = 0;
    int   p_run      = 0;
    logic p_lag      = 1'b0;

    always @(negedge baud_clk) begin
        if (reset) begin
            piso_active = 1'b0;
            piso_done   = 1'b1;
            p_start     = 0;
            p_run       = 0;
            p_lag       = 1'b0;
        end else if (p_start > 0) begin
            p_start--;
            if (p_start == 0) begin
                piso_active = 1'b1;
                piso_done   = 1'b0;
                p_run       = piso_len;
            end
        end else if (piso_active) begin
            p_run--;
            if (p_run == 0) begin
                piso_active = 1'b0;
                if (piso_lag) p_lag = 1'b1;
                else          piso_done = 1'b1;
            end
        end else if (p_lag) begin
            p_lag     = 1'b0;
            piso_done = 1'b1;
        end else if (piso_send && piso_en) begin
            p_start = piso_delay;
        end
    end

    // Transaction-level reference: round robin from the last winner, fixed
    // offsets from the grant edge, frame end when the PISO goes quiet.
    function automatic int rr_pick(input int last_w, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last_w + k) % NREQ]) return (last_w + k) % NREQ;
        end
        return 0;
    endfunction

    logic       model_on = 1'b0;
    int         cyc      = 0;
    int         m_phase  = M_IDLE;
    int         m_t      = 0;
    int         m_ready  = 0;
    int         m_last   = NREQ - 1;
    int         m_owner  = 0;
    logic [7:0] m_data   = 8'h00;
    logic       m_par    = 1'b0;
    int         m_quiet  = (GAP > 0 ? GAP : 1) + 1;

    always @(posedge baud_clk) begin
        logic [NREQ-1:0]   r_s;
        logic [NREQ-1:0]   e_ack;
        logic [NREQ-1:0]   e_done;
        logic [8*NREQ-1:0] d_s;
        logic              en_s, pt_s, act_s, dn_s, rst_s;
        logic              e_send, e_to, e_busy;
        int                w;
        r_s = req; d_s = req_data; en_s = enable; pt_s = parity_type;
        act_s = piso_active; dn_s = piso_done; rst_s = reset;
        cyc++;
        e_ack = '0; e_done = '0; e_send = 1'b0; e_to = 1'b0;
        if (rst_s) begin
            m_phase = M_IDLE; m_last = NREQ - 1; m_owner = 0; m_data = 8'h00; m_par = 1'b0;
        end else begin
            if (m_phase == M_QUIET && cyc >= m_ready) m_phase = M_IDLE;
            case (m_phase)
                M_IDLE: begin
                    if (en_s && r_s != '0) begin
                        w       = rr_pick(m_last, r_s);
                        e_ack   = NREQ'(1) << w;
                        m_data  = d_s[8*w +: 8];
                        m_par   = (^m_data) ^ pt_s;
                        m_owner = w;
                        m_last  = w;
                        m_phase = M_SEND;
                        m_t     = 0;
                    end
                end
                M_SEND: begin
                    m_t++;
                    e_send = (m_t == 1);
                    if (m_t >= 3) begin
                        if (act_s) begin
                            m_phase = M_FRAME;
                        end else if (m_t == 2 + TO) begin
                            e_to    = 1'b1;
                            m_phase = M_QUIET;
                            m_ready = cyc + m_quiet;
                        end
                    end
                end
                M_FRAME: begin
                    if (!act_s && dn_s) begin
                        e_done  = NREQ'(1) << m_owner;
                        m_phase = M_QUIET;
                        m_ready = cyc + m_quiet;
                    end
                end
                default: ;
            endcase
        end
        e_busy = !(m_phase == M_IDLE || (m_phase == M_QUIET && cyc >= m_ready - 1));
        #1;
        if (model_on) begin
            check("rand_cycle",
                  {44'd0, req_ack, req_done, piso_send, timeout_err, busy, owner, piso_data, piso_parity},
                  {44'd0, e_ack, e_done, e_send, e_to, e_busy, IW'(m_owner), m_data, m_par});
        end
    end

    function automatic logic watched(input int sel);
        case (sel)
            0:       return |req_ack;
            1:       return |req_done;
            2:       return piso_active;
            default: return timeout_err;
        endcase
    endfunction

    task automatic wait_for(input string name, input int sel, input int limit, output int waited);
        waited = 0;
        while (!watched(sel) && waited < limit) begin
            @(negedge baud_clk);
            waited++;
        end
        if (!watched(sel)) begin
            checks++;
            failures++;
            $display("FAIL %s: event absent after %0d cycles, required within %0d", name, waited, limit);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge baud_clk);
        @(negedge baud_clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [NREQ-1:0]   rq;
        logic [8*NREQ-1:0] dat;
        logic              pt;
        logic [NREQ-1:0]   ack;
        logic [IW-1:0]     own;
        logic [7:0]        data;
        logic              par;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms, required to finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        int acks;
        logic seen;

        reset = 1'b1; enable = 1'b0; parity_type = 1'b0; req = '0; req_data = '0;
        @(negedge baud_clk);
        check("rst_ack", req_ack, 0);
        check("rst_done", req_done, 0);
        check("rst_send", piso_send, 0);
        check("rst_data", piso_data, 0);
        check("rst_par", piso_parity, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_to", timeout_err, 0);
        @(negedge baud_clk);
        reset = 1'b0;

        // Single request from requester 0.
        req_data = 24'h0000A5; parity_type = 1'b0; req = 3'b001; enable = 1'b1;
        wait_for("t1_ack_wait", 0, 10, w);
        check("t1_ack", req_ack, 3'b001);
        check("t1_data", piso_data, 8'hA5);
        check("t1_par", piso_parity, 0);
        check("t1_send_pre", piso_send, 0);
        req = '0;
        @(negedge baud_clk); check("t1_send_hi", piso_send, 1);
        @(negedge baud_clk); check("t1_send_lo", piso_send, 0);
        wait_for("t1_done_wait", 1, 30, w);
        check("t1_done", req_done, 3'b001);
        @(negedge baud_clk); check("t1_busy_gap", busy, 1);
        @(negedge baud_clk); check("t1_busy_idle", busy, 0);

        // Vector table: fairness with all requesters held high, then parity cases.
        do_reset();
        tbl[0] = '{3'b111, 24'hC35AFF, 1'b0, 3'b001, 2'd0, 8'hFF, 1'b0};
        tbl[1] = '{3'b111, 24'hC35AFF, 1'b1, 3'b010, 2'd1, 8'h5A, 1'b1};
        tbl[2] = '{3'b111, 24'hC35AFF, 1'b0, 3'b100, 2'd2, 8'hC3, 1'b0};
        tbl[3] = '{3'b111, 24'h133456, 1'b0, 3'b001, 2'd0, 8'h56, 1'b0};
        tbl[4] = '{3'b111, 24'h133456, 1'b1, 3'b010, 2'd1, 8'h34, 1'b0};
        tbl[5] = '{3'b111, 24'h133456, 1'b0, 3'b100, 2'd2, 8'h13, 1'b1};
        tbl[6] = '{3'b001, 24'h000007, 1'b1, 3'b001, 2'd0, 8'h07, 1'b0};
        tbl[7] = '{3'b001, 24'h000003, 1'b1, 3'b001, 2'd0, 8'h03, 1'b1};
        tbl[8] = '{3'b100, 24'h800000, 1'b0, 3'b100, 2'd2, 8'h80, 1'b1};
        tbl[9] = '{3'b010, 24'h00FE00, 1'b1, 3'b010, 2'd1, 8'hFE, 1'b0};
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].rq; req_data = tbl[i].dat; parity_type = tbl[i].pt;
            wait_for($sformatf("v%0d_ack_wait", i), 0, 20, w);
            check($sformatf("v%0d_ack", i), req_ack, tbl[i].ack);
            check($sformatf("v%0d_owner", i), owner, tbl[i].own);
            check($sformatf("v%0d_data", i), piso_data, tbl[i].data);
            check($sformatf("v%0d_par", i), piso_parity, tbl[i].par);
            wait_for($sformatf("v%0d_done_wait", i), 1, 40, w);
            check($sformatf("v%0d_done", i), req_done, tbl[i].ack);
        end

        // Start timeout: PISO never goes active.
        piso_en = 1'b0; req = 3'b100; req_data = 24'hAB0000;
        wait_for("to_ack_wait", 0, 20, w);
        check("to_ack", req_ack, 3'b100);
        req = '0; n = 0; seen = 1'b0;
        while (!timeout_err && n < 20) begin
            @(negedge baud_clk); n++;
            if (|req_done) seen = 1'b1;
        end
        check("to_latency", n, 6);
        piso_en = 1'b1; req = 3'b001; req_data = 24'h000011;
        for (int k = 0; k < 2; k++) begin
            @(negedge baud_clk);
            if (|req_done) seen = 1'b1;
        end
        check("to_no_done", seen, 0);
        wait_for("to_next_ack_wait", 0, 10, w);
        check("to_next_ack", req_ack, 3'b001);
        wait_for("to_next_done_wait", 1, 40, w);
        check("to_next_done", req_done, 3'b001);

        // Enable dropped while the frame is on the line.
        req = 3'b010; req_data = 24'h003C00;
        wait_for("en_ack_wait", 0, 20, w);
        check("en_ack", req_ack, 3'b010);
        wait_for("en_act_wait", 2, 20, w);
        @(negedge baud_clk);
        enable = 1'b0;
        wait_for("en_done_wait", 1, 40, w);
        check("en_done", req_done, 3'b010);
        acks = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge baud_clk);
            if (|req_ack) acks++;
        end
        check("en_hold_no_ack", acks, 0);
        check("en_hold_idle", busy, 0);
        enable = 1'b1;
        wait_for("en_resume_wait", 0, 10, w);
        check("en_resume_ack", req_ack, 3'b010);
        wait_for("en_resume_done_wait", 1, 40, w);

        // Reset while waiting for frame completion.
        req = 3'b010; req_data = 24'h005A00;
        wait_for("rs_ack_wait", 0, 20, w);
        check("rs_ack", req_ack, 3'b010);
        wait_for("rs_act_wait", 2, 20, w);
        @(negedge baud_clk);
        check("rs_busy_pre", busy, 1);
        req = 3'b111;
        #2 reset = 1'b1;
        #1;
        check("rs_busy", busy, 0);
        check("rs_owner", owner, 0);
        check("rs_data", piso_data, 0);
        check("rs_done", req_done, 0);
        @(negedge baud_clk);
        @(negedge baud_clk);
        reset = 1'b0;
        wait_for("rs_next_wait", 0, 10, w);
        check("rs_next_ack", req_ack, 3'b001);
        wait_for("rs_next_done_wait", 1, 40, w);

        // Randomized traffic against the reference model.
        do_reset();
        model_on = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
            req_data    = 24'($urandom);
            parity_type = 1'($urandom);
            enable      = ($urandom_range(0, 9) != 0);
            piso_en     = ($urandom_range(0, 7) != 0);
            piso_delay  = $urandom_range(2, 4);
            piso_len    = $urandom_range(1, 8);
            piso_lag    = 1'($urandom);
            @(negedge baud_clk);
        end
        @(negedge baud_clk);
        model_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
